vlg_pulse_cnt_mc: RTL
=====================

// Module: vlg_pulse_cnt_mc
// PURPOSE
//  Multi-channel pulse edge counter, successor of the single-channel rising-edge counter.
//  Per channel: input synchroniser, edge detect in a programmable mode (rise/fall/both/off),
//  per-channel enable, wrap or saturating count, sticky overflow flag.
//  Global clear, plus an atomic all-channel snapshot for register/readout logic.
//  Sits between asynchronous pulse sources (sensor/GPIO) and a status register bank.
// PARAMETERS
//  CH_NUM       4   number of independent channels (1..16)
//  CNT_W        16  counter width per channel (2..32)
//  SYNC_STAGES  2   synchroniser flops per channel (2..4)
//  SAT_EN       1   1: counters saturate at all-ones; 0: counters wrap to 0
// PORTS
//  i_clk         in   1             single clock, all logic rising-edge
//  i_rst_n       in   1             asynchronous active-low reset
//  i_pulse       in   CH_NUM        raw pulse inputs, asynchronous to i_clk
//  i_en          in   CH_NUM        per-channel count enable; low clears that channel
//  i_edge_mode   in   2*CH_NUM      ch k at [2k+1:2k]: 00 rise, 01 fall, 10 both, 11 off
//  i_clr         in   1             synchronous clear of all counters and overflow flags
//  i_snap        in   1             capture all counters into o_snap_cnt
//  o_pulse_cnt   out  CH_NUM*CNT_W  live counts, ch k at [k*CNT_W +: CNT_W]
//  o_snap_cnt    out  CH_NUM*CNT_W  snapshot counts, same packing
//  o_snap_vld    out  1             one-cycle strobe: o_snap_cnt updated
//  o_ovf         out  CH_NUM        sticky per-channel overflow flag
// BEHAVIOUR
//  Reset (i_rst_n=0, async): sync chains, edge-history flops, o_pulse_cnt, o_snap_cnt,
//    o_snap_vld, o_ovf all 0. Release is synchronous in effect; no counting on release cycle.
//  Sync/edge: chain s[0..SYNC_STAGES-1] plus history flop d (d <= s[last]) always run,
//    independent of i_en. rise = s[last]&~d, fall = ~s[last]&d; mode selects which counts.
//  Latency: input first sampled high at edge N -> o_pulse_cnt incremented after edge
//    N+SYNC_STAGES. Input pulses must be high/low >= SYNC_STAGES+1 clocks to be counted.
//  Mode change takes effect the same cycle (combinational select); mode 11 never counts.
//  Per-channel update priority at each edge:
//    1 i_clr=1          -> cnt<=0, ovf<=0 (all channels)
//    2 i_en[k]=0        -> cnt<=0, ovf<=0
//    3 edge detected    -> cnt==all-ones: SAT_EN=1 hold all-ones, SAT_EN=0 wrap to 0;
//                          ovf<=1 in both cases; else cnt<=cnt+1
//    4 otherwise hold
//  Re-enabling with input already high produces no edge (history kept while disabled).
//  Snapshot: i_snap=1 at edge E -> o_snap_cnt <= o_pulse_cnt values before edge E,
//    o_snap_vld=1 for the cycle after E only. i_snap with i_clr: snapshot holds pre-clear
//    values, counters go to 0. Back-to-back i_snap: o_snap_vld high each cycle.
//  o_snap_cnt holds until next i_snap or reset; unaffected by i_clr and i_en.
//  Reset asserted mid-operation: all state clears immediately, no partial update.
// TESTING
//  T1 CH0 mode 00, en=1, 5 pulses (4 high/4 low clk) -> cnt0=5, ovf0=0; first inc exactly
//     SYNC_STAGES edges after first high sample; other channels 0.
//  T2 CH1 mode 01, CH2 mode 10, 3 pulses each -> cnt1=3, cnt2=6; CH3 mode 11 -> cnt3=0.
//  T3 CNT_W=4: 17 rising pulses on CH0; SAT_EN=1 -> cnt0=15, ovf0=1; SAT_EN=0 -> cnt0=1, ovf0=1.
//  T4 cnt0=7, drop i_en[0] one cycle while input high, re-raise -> cnt0=0, ovf0=0, no
//     spurious count; next pulse -> cnt0=1.
//  T5 cnt={3,2,1,0}, i_snap=1 with i_clr=1 same edge -> o_snap_cnt={3,2,1,0}, o_snap_vld
//     high one cycle, o_pulse_cnt all 0.
//  T6 assert i_rst_n low mid-count asynchronously (between edges) -> all outputs 0 before
//     next edge; after release, next pulse counts from 1.

Source files
------------

// File: rtl/vlg_pulse_cnt_mc.sv
// Multi-channel pulse edge counter: per-channel synchroniser, programmable edge
// detect, enable, wrap/saturate count with sticky overflow, plus atomic snapshot.
module vlg_pulse_cnt_mc #(
   parameter int unsigned CH_NUM      = 4,
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned SAT_EN      = 1
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic [CH_NUM-1:0]         i_pulse,
   input  logic [CH_NUM-1:0]         i_en,
   input  logic [2*CH_NUM-1:0]       i_edge_mode,
   input  logic                      i_clr,
   input  logic                      i_snap,
   output logic [CH_NUM*CNT_W-1:0]   o_pulse_cnt,
   output logic [CH_NUM*CNT_W-1:0]   o_snap_cnt,
   output logic                      o_snap_vld,
   output logic [CH_NUM-1:0]         o_ovf
);

   typedef enum logic [1:0] {
      EDGE_RISE = 2'b00,
      EDGE_FALL = 2'b01,
      EDGE_BOTH = 2'b10,
      EDGE_OFF  = 2'b11
   } edge_mode_e;

   logic [SYNC_STAGES-1:0] sync_q [CH_NUM];
   logic [CH_NUM-1:0]      hist_q;
   logic [CNT_W-1:0]       cnt_q  [CH_NUM];
   logic [CNT_W-1:0]       cnt_d  [CH_NUM];
   logic [CNT_W-1:0]       snap_q [CH_NUM];
   logic [CH_NUM-1:0]      ovf_q, ovf_d;
   logic                   snap_vld_q;

   logic [CH_NUM-1:0]      s_last, rise, fall, hit;
   edge_mode_e             mode [CH_NUM];

   // Edge history keeps running while a channel is disabled, so re-enabling
   // with the input already high does not fabricate an edge.
   always_comb begin
      s_last = '0;
      rise   = '0;
      fall   = '0;
      hit    = '0;
      for (int unsigned k = 0; k < CH_NUM; k++) begin
         mode[k]   = edge_mode_e'(i_edge_mode[2*k +: 2]);
         s_last[k] = sync_q[k][SYNC_STAGES-1];
         rise[k]   = s_last[k] & ~hist_q[k];
         fall[k]   = ~s_last[k] & hist_q[k];
         case (mode[k])
            EDGE_RISE: hit[k] = rise[k];
            EDGE_FALL: hit[k] = fall[k];
            EDGE_BOTH: hit[k] = rise[k] | fall[k];
            default:   hit[k] = 1'b0;
         endcase
      end
   end

   always_comb begin
      ovf_d = ovf_q;
      for (int unsigned k = 0; k < CH_NUM; k++) begin
         cnt_d[k] = cnt_q[k];
         if (i_clr || !i_en[k]) begin
            cnt_d[k] = '0;
            ovf_d[k] = 1'b0;
         end else if (hit[k]) begin
            if (&cnt_q[k]) begin
               cnt_d[k] = (SAT_EN != 0) ? '1 : '0;
               ovf_d[k] = 1'b1;
            end else begin
               cnt_d[k] = cnt_q[k] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int unsigned k = 0; k < CH_NUM; k++) begin
            sync_q[k] <= '0;
            cnt_q[k]  <= '0;
            snap_q[k] <= '0;
         end
         hist_q     <= '0;
         ovf_q      <= '0;
         snap_vld_q <= 1'b0;
      end else begin
         for (int unsigned k = 0; k < CH_NUM; k++) begin
            sync_q[k] <= {sync_q[k][SYNC_STAGES-2:0], i_pulse[k]};
            cnt_q[k]  <= cnt_d[k];
            if (i_snap) begin
               snap_q[k] <= cnt_q[k];
            end
         end
         hist_q     <= s_last;
         ovf_q      <= ovf_d;
         snap_vld_q <= i_snap;
      end
   end

   always_comb begin
      o_pulse_cnt = '0;
      o_snap_cnt  = '0;
      for (int unsigned k = 0; k < CH_NUM; k++) begin
         o_pulse_cnt[k*CNT_W +: CNT_W] = cnt_q[k];
         o_snap_cnt[k*CNT_W +: CNT_W]  = snap_q[k];
      end
   end

   assign o_snap_vld = snap_vld_q;
   assign o_ovf      = ovf_q;

endmodule
